// File: rtl/nlu_pass_sequencer.sv
// nlu_pass_sequencer: control side of the nonlinear-unit operand selector.
// Accepts elements, issues one or two datapath passes per element and returns
// the results. Softmax is vector-level: pass 1 streams every element through
// exp into a buffer while accumulating the sum, and pass 2 replays the buffer
// through divide using that sum.
// Optional feature: define NLU_SEQ_SAT_SUM_EN to make the softmax sum saturate
// on unsigned overflow. Without it the sum wraps modulo 2^W.
module nlu_pass_sequencer #(
   parameter int FIX_POINT_WIDTH = 16,
   parameter int DEPTH           = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [FIX_POINT_WIDTH-1:0] in_data,
   input  logic [FIX_POINT_WIDTH-1:0] in_max,
   input  logic                       in_last,
   output logic [2:0]                 dp_s,
   output logic [FIX_POINT_WIDTH-1:0] dp_x,
   output logic [FIX_POINT_WIDTH-1:0] dp_max,
   output logic [FIX_POINT_WIDTH-1:0] dp_mid,
   output logic [FIX_POINT_WIDTH-1:0] dp_sum,
   output logic                       dp_valid,
   input  logic                       dp_res_valid,
   input  logic [FIX_POINT_WIDTH-1:0] dp_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FIX_POINT_WIDTH-1:0] out_data,
   output logic                       out_last,
   output logic                       err_ovf
);
   localparam int W  = FIX_POINT_WIDTH;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [3:0] {
      IDLE, SM_ISS1, SM_WAIT1, SM_ISS2, SM_WAIT2, SM_OUT,
      G_ISS1, G_WAIT1, G_ISS2, G_WAIT2, RT_ISS, RT_WAIT, OUT
   } state_t;

   state_t          state_q, state_d;
   logic            pend_q, pend_d;       // softmax element captured, not yet issued
   logic            last_q, last_d;       // captured softmax element closes the vector
   logic [2:0]      dp_s_q, dp_s_d;
   logic [W-1:0]    dp_x_q, dp_x_d;
   logic [W-1:0]    dp_max_q, dp_max_d;
   logic [W-1:0]    dp_mid_q, dp_mid_d;
   logic [W-1:0]    dp_sum_q, dp_sum_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic            err_ovf_q, err_ovf_d;

   logic [W-1:0]    sm_buf [DEPTH];
   logic            buf_we;
   logic [W:0]      sum_add;
   logic [W-1:0]    sum_nxt;
   logic            at_cap;               // the element being accepted is the DEPTH-th one

   assign sum_add = {1'b0, sum_q} + {1'b0, dp_res};
`ifdef NLU_SEQ_SAT_SUM_EN
   assign sum_nxt = sum_add[W] ? {W{1'b1}} : sum_add[W-1:0];
`else
   assign sum_nxt = sum_add[W-1:0];
`endif
   assign at_cap = (cnt_q == CW'(DEPTH - 1));

   assign dp_s      = dp_s_q;
   assign dp_x      = dp_x_q;
   assign dp_max    = dp_max_q;
   assign dp_mid    = dp_mid_q;
   assign dp_sum    = dp_sum_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign err_ovf   = err_ovf_q;

   // Next-state, issue strobe and handshake decode
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      last_d      = last_q;
      dp_s_d      = dp_s_q;
      dp_x_d      = dp_x_q;
      dp_max_d    = dp_max_q;
      dp_mid_d    = dp_mid_q;
      dp_sum_d    = dp_sum_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      err_ovf_d   = err_ovf_q;
      buf_we      = 1'b0;
      in_ready    = 1'b0;
      dp_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               dp_x_d = in_data;
               case (mode)
                  2'b00: begin
                     dp_s_d   = 3'd0;
                     dp_max_d = in_max;
                     last_d   = in_last | at_cap;
                     if (at_cap && !in_last) err_ovf_d = 1'b1;
                     pend_d   = 1'b1;
                     state_d  = SM_ISS1;
                  end
                  2'b01, 2'b10: begin
                     dp_s_d  = 3'd2;
                     state_d = G_ISS1;
                  end
                  default: begin
                     dp_s_d  = 3'd4;
                     state_d = RT_ISS;
                  end
               endcase
            end
         end
         // Either issues the captured element or waits for the next one
         SM_ISS1: begin
            if (pend_q) begin
               dp_valid = 1'b1;
               pend_d   = 1'b0;
               state_d  = SM_WAIT1;
            end else begin
               in_ready = 1'b1;
               if (in_valid) begin
                  dp_x_d = in_data;
                  last_d = in_last | at_cap;
                  if (at_cap && !in_last) err_ovf_d = 1'b1;
                  pend_d = 1'b1;
               end
            end
         end
         SM_WAIT1: begin
            if (dp_res_valid) begin
               buf_we = 1'b1;
               sum_d  = sum_nxt;
               cnt_d  = cnt_q + CW'(1);
               if (last_q) begin
                  // buf[0] is being written this cycle for a one-element vector
                  dp_s_d   = 3'd1;
                  dp_sum_d = sum_nxt;
                  dp_mid_d = (cnt_q == '0) ? dp_res : sm_buf[0];
                  rd_d     = '0;
                  state_d  = SM_ISS2;
               end else begin
                  state_d = SM_ISS1;
               end
            end
         end
         SM_ISS2: begin
            dp_valid = 1'b1;
            state_d  = SM_WAIT2;
         end
         SM_WAIT2: begin
            if (dp_res_valid) begin
               out_data_d  = dp_res;
               out_valid_d = 1'b1;
               out_last_d  = ((CW'(rd_q) + CW'(1)) == cnt_q);
               state_d     = SM_OUT;
            end
         end
         SM_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  sum_d   = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  rd_d     = rd_q + AW'(1);
                  dp_mid_d = sm_buf[rd_q + AW'(1)];
                  state_d  = SM_ISS2;
               end
            end
         end
         G_ISS1: begin
            dp_valid = 1'b1;
            state_d  = G_WAIT1;
         end
         G_WAIT1: begin
            if (dp_res_valid) begin
               dp_mid_d = dp_res;
               dp_s_d   = 3'd3;
               state_d  = G_ISS2;
            end
         end
         G_ISS2: begin
            dp_valid = 1'b1;
            state_d  = G_WAIT2;
         end
         G_WAIT2, RT_WAIT: begin
            if (dp_res_valid) begin
               out_data_d  = dp_res;
               out_valid_d = 1'b1;
               out_last_d  = 1'b1;
               state_d     = OUT;
            end
         end
         RT_ISS: begin
            dp_valid = 1'b1;
            state_d  = RT_WAIT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_q      <= 1'b0;
         last_q      <= 1'b0;
         dp_s_q      <= '0;
         dp_x_q      <= '0;
         dp_max_q    <= '0;
         dp_mid_q    <= '0;
         dp_sum_q    <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         rd_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         last_q      <= last_d;
         dp_s_q      <= dp_s_d;
         dp_x_q      <= dp_x_d;
         dp_max_q    <= dp_max_d;
         dp_mid_q    <= dp_mid_d;
         dp_sum_q    <= dp_sum_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   // Softmax exp buffer; contents are only read after being written in the same job
   always_ff @(posedge clk) begin
      if (buf_we) sm_buf[cnt_q[AW-1:0]] <= dp_res;
   end

endmodule

// File: tb/tb_nlu_pass_sequencer.sv
// Bench for nlu_pass_sequencer: a datapath stub answers each issue one cycle
// later, expected outputs are queued at stimulus time and a monitor pops and
// compares them on every output handshake.
module tb_nlu_pass_sequencer;
   localparam int W = 16;
   localparam int D = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic          in_valid, in_ready, in_last;
   logic [W-1:0]  in_data, in_max;
   logic [2:0]    dp_s;
   logic [W-1:0]  dp_x, dp_max, dp_mid, dp_sum, dp_res;
   logic          dp_valid, dp_res_valid;
   logic          out_valid, out_ready, out_last, err_ovf;
   logic [W-1:0]  out_data;

   nlu_pass_sequencer #(.FIX_POINT_WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_max(in_max), .in_last(in_last), .dp_s(dp_s), .dp_x(dp_x),
      .dp_max(dp_max), .dp_mid(dp_mid), .dp_sum(dp_sum), .dp_valid(dp_valid),
      .dp_res_valid(dp_res_valid), .dp_res(dp_res), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           n_chk = 0;
   int           n_err = 0;
   logic [W-1:0] exp_sum = '0;
   logic [W-1:0] exp_max = '0;
   logic         st_pend = 1'b0;
   logic [W-1:0] st_val = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Datapath stub: exp = identity, divide = mid ^ sum, gelu/silu = s*0x10+1, root = x+1
   always @(negedge clk) begin
      dp_res_valid = st_pend;
      dp_res       = st_val;
      st_pend      = dp_valid;
      if (dp_valid) begin
         case (dp_s)
            3'd0: begin chk("sm_p1_max", 32'(dp_max), 32'(exp_max)); st_val = dp_x; end
            3'd1: begin chk("sm_p2_sum", 32'(dp_sum), 32'(exp_sum)); st_val = dp_mid ^ dp_sum; end
            3'd2: st_val = 16'h0021;
            3'd3: begin chk("gs_p2_mid", 32'(dp_mid), 32'h0021); st_val = 16'h0031; end
            3'd4: st_val = dp_x + 16'd1;
            default: begin chk("dp_s_code", 32'(dp_s), 32'h0); st_val = '0; end
         endcase
      end
   end

   // Output monitor
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_out: got %h want none", out_data);
         end else begin
            mon_e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(mon_e.d));
            chk("out_last", 32'(out_last), 32'(mon_e.l));
         end
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] mx, input logic l,
                       input logic [1:0] md);
      int  t;
      bit  done;
      in_valid = 1'b1; in_data = x; in_max = mx; in_last = l; mode = md;
      t = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) done = 1;
         else if (++t > 1000) begin
            n_chk++; n_err++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
            done = 1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         n_chk++; n_err++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic latency(input string nm, input int want);
      int lat;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk(nm, 32'(lat), 32'(want));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] sat_sum;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_max = '0; in_last = 1'b0;
      mode = 2'b00; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;

      // reset state
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_dp_valid", 32'(dp_valid), 32'h0);
      chk("rst_out_last", 32'(out_last), 32'h0);
      chk("rst_err_ovf", 32'(err_ovf), 32'h0);
      chk("rst_dp_x", 32'(dp_x), 32'h0);
      chk("rst_dp_sum", 32'(dp_sum), 32'h0);

      // gelu and silu: two passes, mid = first result
      sb.push_back('{16'h0031, 1'b1});
      send(16'h0100, 16'h0, 1'b0, 2'b01);
      latency("gelu_latency", 4);
      drain();
      sb.push_back('{16'h0031, 1'b1});
      send(16'h0200, 16'h0, 1'b0, 2'b10);
      drain();

      // root: one pass
      sb.push_back('{16'h0401, 1'b1});
      send(16'h0400, 16'h0, 1'b0, 2'b11);
      latency("root_latency", 2);
      drain();

      // root with downstream stalled for 10 cycles
      out_ready = 1'b0;
      sb.push_back('{16'h0401, 1'b1});
      send(16'h0400, 16'h0, 1'b0, 2'b11);
      for (int t = 0; t < 50 && !out_valid; t++) begin @(posedge clk); #1; end
      for (int c = 0; c < 10; c++) begin
         chk("stall_out_valid", 32'(out_valid), 32'h1);
         chk("stall_out_data", 32'(out_data), 32'h0401);
         chk("stall_in_ready", 32'(in_ready), 32'h0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      drain();

      // softmax, 4 elements of exp 0x40 -> sum 0x100
      exp_max = 16'h1234; exp_sum = 16'h0100;
      for (int i = 0; i < 4; i++) sb.push_back('{16'h0140, (i == 3)});
      for (int i = 0; i < 4; i++) send(16'h0040, 16'h1234, (i == 3), 2'b00);
      drain();

      // softmax sum overflow
`ifdef NLU_SEQ_SAT_SUM_EN
      sat_sum = 16'hFFFF;
`else
      sat_sum = 16'h8000;
`endif
      exp_max = 16'h0007; exp_sum = sat_sum;
      sb.push_back('{16'hC000 ^ sat_sum, 1'b0});
      sb.push_back('{16'hC000 ^ sat_sum, 1'b1});
      send(16'hC000, 16'h0007, 1'b0, 2'b00);
      send(16'hC000, 16'h0007, 1'b1, 2'b00);
      drain();

      // DEPTH+1 elements without in_last: first DEPTH form one vector
      exp_max = 16'h0055; exp_sum = 16'(D * (D + 1) / 2);
      for (int i = 0; i < D; i++) sb.push_back('{16'(i + 1) ^ exp_sum, (i == D - 1)});
      for (int i = 0; i < D; i++) send(16'(i + 1), 16'h0055, 1'b0, 2'b00);
      chk("ovf_err_set", 32'(err_ovf), 32'h1);
      send(16'h0100, 16'h0055, 1'b0, 2'b00);
      chk("ovf_drained_before_next", 32'(sb.size()), 32'h0);
      exp_sum = 16'h0300;
      sb.push_back('{16'h0200, 1'b0});
      sb.push_back('{16'h0100, 1'b1});
      send(16'h0200, 16'h0055, 1'b1, 2'b00);
      drain();
      chk("ovf_err_sticky", 32'(err_ovf), 32'h1);

      // reset in the middle of softmax pass 1
      exp_max = 16'h0011;
      for (int i = 0; i < 3; i++) send(16'h0009, 16'h0011, 1'b0, 2'b00);
      repeat (4) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 32'h1);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_err_ovf", 32'(err_ovf), 32'h0);
      exp_sum = 16'h0030;
      sb.push_back('{16'h0020, 1'b0});
      sb.push_back('{16'h0010, 1'b1});
      send(16'h0010, 16'h0011, 1'b0, 2'b00);
      send(16'h0020, 16'h0011, 1'b1, 2'b00);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
